uart_tx_fifo_drain: RTL and testbench

//  Transmit-side consumer of the UART output FIFO. Pops one DATA_SIZE-bit SEC-DED codeword at a time
//  and serialises it onto tx as an 8N1-style frame (1 start bit, DATA_SIZE data bits LSB first, 1 stop bit).
//  Bit timing comes from the shared oversampling tick s_tick. Sits between the FIFO (read side) and the pin.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo_drain.sv | 95 +++++++++
 tb/tb_uart_tx_fifo_drain.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and default bit-timing constants
// shared by the UART transmitter and receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int SB_TICK_DEF    = 16;

   function automatic int tick_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops one codeword per frame from the TX FIFO
// and shifts it out LSB first between a start and a stop bit.
module uart_tx_fifo_drain
   import uart_pkg::*;
#(
   parameter int DATA_SIZE  = 10,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int SB_TICK    = SB_TICK_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 s_tick,
   input  logic                 empty,
   input  logic [DATA_SIZE-1:0] r_data,
   output logic                 rd,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done_tick
);

   localparam int TW = tick_width(OVERSAMPLE, SB_TICK);
   localparam int BW = (DATA_SIZE <= 2) ? 1 : $clog2(DATA_SIZE);

   localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_SIZE - 1);

   uart_state_t          state;
   logic [TW-1:0]        s_cnt;
   logic [BW-1:0]        n_cnt;
   logic [DATA_SIZE-1:0] shreg;
   logic                 tx_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         s_cnt  <= '0;
         n_cnt  <= '0;
         shreg  <= '0;
         tx_reg <= 1'b1;
      end else if (s_tick) begin
         unique case (state)
            IDLE: begin
               if (!empty) begin
                  state  <= START;
                  s_cnt  <= '0;
                  shreg  <= r_data;
                  tx_reg <= 1'b0;
               end
            end
            START: begin
               if (s_cnt == OS_LAST) begin
                  state  <= DATA;
                  s_cnt  <= '0;
                  n_cnt  <= '0;
                  tx_reg <= shreg[0];
               end else begin
                  s_cnt <= s_cnt + 1'b1;
               end
            end
            DATA: begin
               if (s_cnt == OS_LAST) begin
                  s_cnt <= '0;
                  shreg <= shreg >> 1;
                  // tx is loaded one bit ahead so the line never glitches
                  if (n_cnt == BIT_LAST) begin
                     state  <= STOP;
                     tx_reg <= 1'b1;
                  end else begin
                     n_cnt  <= n_cnt + 1'b1;
                     tx_reg <= shreg[1];
                  end
               end else begin
                  s_cnt <= s_cnt + 1'b1;
               end
            end
            STOP: begin
               if (s_cnt == SB_LAST) begin
                  state <= IDLE;
                  s_cnt <= '0;
               end else begin
                  s_cnt <= s_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   assign rd = ~reset & s_tick & ~empty & (state == IDLE);
   assign tx_done_tick = ~reset & s_tick & (state == STOP)
                       & (s_cnt == SB_LAST);
   assign tx      = tx_reg;
   assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: FIFO model feeds the drain, a scoreboard
// of pushed words is checked tick by tick against the serial line.
module tb_uart_tx_fifo_drain;

   localparam int DS    = 10;
   localparam int OS    = 16;
   localparam int SB    = 16;
   localparam int TOTAL = OS * (DS + 1) + SB;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          s_tick = 1'b0;
   logic          empty = 1'b1;
   logic [DS-1:0] r_data = '0;
   logic          rd, tx, tx_busy, tx_done_tick;

   uart_tx_fifo_drain #(
      .DATA_SIZE (DS),
      .OVERSAMPLE(OS),
      .SB_TICK   (SB)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .s_tick      (s_tick),
      .empty       (empty),
      .r_data      (r_data),
      .rd          (rd),
      .tx          (tx),
      .tx_busy     (tx_busy),
      .tx_done_tick(tx_done_tick)
   );

   always #5 clk = ~clk;

   logic [DS-1:0] fifo[$];
   logic [DS-1:0] exp_q[$];
   logic [DS-1:0] cur = '0;

   int total = 0;
   int bad = 0;
   int div = 1;
   int divcnt = 0;
   int cyc = 0;
   int tk = 0;
   int j = 0;
   int pop_cyc = 0;
   int frames = 0;
   int rd_cnt = 0;
   int last_done_tk = -100;
   int last_gap = 0;
   bit in_frame = 1'b0;
   bit rst_prev = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h tick=%0d cyc=%0d",
                  tag, got, exp, tk, cyc);
      end
   endtask

   function automatic logic exp_bit(input logic [DS-1:0] w,
                                    input int idx);
      if (idx < OS) return 1'b0;
      if (idx < OS * (DS + 1)) return w[(idx - OS) / OS];
      return 1'b1;
   endfunction

   task automatic monitor();
      if (rst_prev) begin
         chk("rst_tx", tx, 1);
         chk("rst_busy", tx_busy, 0);
      end
      if (reset) begin
         chk("rst_rd", rd, 0);
         chk("rst_done", tx_done_tick, 0);
         in_frame = 1'b0;
      end else if (in_frame) begin
         chk("busy", tx_busy, 1);
         chk("rd_mid", rd, 0);
         if (s_tick) begin
            j++;
            chk("tx", tx, exp_bit(cur, j - 1));
            chk("done", tx_done_tick, 32'(j == TOTAL));
            if (j == TOTAL) begin
               in_frame = 1'b0;
               frames++;
               chk("dur", cyc - pop_cyc, TOTAL * div);
               last_done_tk = tk;
            end
         end else begin
            chk("done_hold", tx_done_tick, 0);
         end
      end else begin
         if (!rst_prev) begin
            chk("idle_tx", tx, 1);
            chk("idle_busy", tx_busy, 0);
         end
         chk("idle_done", tx_done_tick, 0);
         if (rd) begin
            chk("rd_cond", {s_tick, empty}, 2'b10);
            rd_cnt++;
            last_gap = tk - last_done_tk;
            if (exp_q.size() == 0) chk("sb_empty", 1, 0);
            else cur = exp_q.pop_front();
            in_frame = 1'b1;
            j = 0;
            pop_cyc = cyc;
         end
      end
      if (s_tick) tk++;
   endtask

   task automatic step();
      bit pop;
      bit rp;
      @(negedge clk);
      monitor();
      pop = rd;
      rp = reset;
      @(posedge clk);
      #1;
      cyc++;
      rst_prev = rp;
      if (pop && fifo.size() > 0) void'(fifo.pop_front());
      divcnt = (divcnt + 1) % div;
      s_tick = (divcnt == 0);
      empty = (fifo.size() == 0);
      r_data = empty ? '0 : fifo[0];
   endtask

   task automatic push(input logic [DS-1:0] w);
      fifo.push_back(w);
      exp_q.push_back(w);
      empty = 1'b0;
      r_data = fifo[0];
   endtask

   task automatic drain(input int limit);
      for (int i = 0; i < limit; i++) begin
         if (!in_frame && exp_q.size() == 0 && fifo.size() == 0) break;
         step();
      end
      chk("drain", {30'd0, in_frame, exp_q.size() != 0}, 0);
   endtask

   task automatic set_div(input int d);
      div = d;
      divcnt = 0;
   endtask

   initial begin
      int r0;
      int f0;
      set_div(2);
      repeat (3) step();
      reset = 1'b0;
      repeat (4) step();

      set_div(4);
      r0 = rd_cnt;
      push(10'h2A5);
      drain(TOTAL * 4 + 50);
      chk("t2_rd", rd_cnt - r0, 1);
      chk("t2_frames", frames, 1);

      r0 = rd_cnt;
      push(10'h001);
      push(10'h3FE);
      drain(2 * TOTAL * 4 + 50);
      chk("t3_rd", rd_cnt - r0, 2);
      chk("t3_gap", last_gap, 1);

      set_div(2);
      r0 = rd_cnt;
      repeat (1000) step();
      chk("t4_rd", rd_cnt - r0, 0);

      set_div(3);
      push(10'h3C3);
      for (int i = 0; i < TOTAL * 3; i++) begin
         if (in_frame && j >= OS * 5 + 8) break;
         step();
      end
      chk("t5_mid", {31'd0, in_frame}, 1);
      f0 = frames;
      r0 = rd_cnt;
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      repeat (3) step();
      chk("t5_nodone", frames, f0);
      chk("t5_nopop", rd_cnt, r0);
      push(10'h155);
      drain(TOTAL * 3 + 50);
      chk("t5_frames", frames, f0 + 1);

      set_div(1);
      push(10'h2A5);
      drain(TOTAL + 50);
      set_div(7);
      push(10'h2A5);
      drain(TOTAL * 7 + 50);
      chk("t6_frames", frames, f0 + 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
